// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between mem_port_arbiter, the Fetch/Mem requesters and the memory bus.
// The master modport is the arbiter's view; slave is the view of its surroundings.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      if_req;
  logic [ADDR_WIDTH-1:0]     if_addr;
  logic                      if_flush;
  logic [DATA_WIDTH-1:0]     if_rdata;
  logic                      if_done;
  logic                      Icache_StallReq;

  logic                      mem_req;
  logic                      mem_we;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [DATA_WIDTH/8-1:0]   mem_be;
  logic [DATA_WIDTH-1:0]     mem_rdata;
  logic                      mem_done;
  logic                      Dcache_StallReq;

  logic                      bus_req;
  logic                      bus_we;
  logic [ADDR_WIDTH-1:0]     bus_addr;
  logic [DATA_WIDTH-1:0]     bus_wdata;
  logic [DATA_WIDTH/8-1:0]   bus_be;
  logic                      bus_gnt;
  logic                      bus_rvalid;
  logic [DATA_WIDTH-1:0]     bus_rdata;

  modport master (
    input  if_req, if_addr, if_flush,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  bus_gnt, bus_rvalid, bus_rdata,
    output if_rdata, if_done, Icache_StallReq,
    output mem_rdata, mem_done, Dcache_StallReq,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be
  );

  modport slave (
    output if_req, if_addr, if_flush,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output bus_gnt, bus_rvalid, bus_rdata,
    input  if_rdata, if_done, Icache_StallReq,
    input  mem_rdata, mem_done, Dcache_StallReq,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-bus arbiter between instruction fetch (I) and Mem-stage data (D) ports.
// One transaction at a time; D has priority, bounded by a starvation counter for I.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst,
  mem_port_arbiter_if.master  port
);

  localparam int         BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t                 state_q,      state_d;
  owner_t                 owner_q,      owner_d;
  logic [3:0]             starve_cnt_q, starve_cnt_d;
  logic                   drop_q,       drop_d;
  logic                   we_q,         we_d;
  logic [ADDR_WIDTH-1:0]  addr_q,       addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q,      wdata_d;
  logic [BE_WIDTH-1:0]    be_q,         be_d;
  logic [DATA_WIDTH-1:0]  if_rdata_q,   if_rdata_d;
  logic [DATA_WIDTH-1:0]  mem_rdata_q,  mem_rdata_d;

  logic i_elig_s;
  logic d_elig_s;
  logic starve_full_s;
  logic grant_d_s;
  logic grant_i_s;
  logic if_done_s;
  logic mem_done_s;

  // A fetch being redirected this cycle is not worth starting.
  assign i_elig_s      = port.if_req & ~port.if_flush;
  assign d_elig_s      = port.mem_req;
  assign starve_full_s = (starve_cnt_q == LIMIT);
  assign grant_d_s     = (state_q == IDLE) & d_elig_s & ~(i_elig_s & starve_full_s);
  assign grant_i_s     = (state_q == IDLE) & i_elig_s & ~grant_d_s;

  // Next-state decode of the transaction sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d_s | grant_i_s) begin
          state_d = ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        if (port.bus_gnt) begin
          state_d = WAIT;
        end else begin
          state_d = ADDR;
        end
      end
      WAIT: begin
        if (port.bus_rvalid) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Owner and bus fields are captured only at grant so later requester changes cannot leak onto the bus.
  always_comb begin
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    if (grant_d_s) begin
      owner_d = OWN_D;
      we_d    = port.mem_we;
      addr_d  = port.mem_addr;
      wdata_d = port.mem_wdata;
      be_d    = port.mem_be;
    end else if (grant_i_s) begin
      owner_d = OWN_I;
      we_d    = 1'b0;
      addr_d  = port.if_addr;
      wdata_d = {DATA_WIDTH{1'b0}};
      be_d    = {BE_WIDTH{1'b1}};
    end else begin
      owner_d = owner_q;
    end
  end

  // Consecutive D grants while a fetch is waiting, saturating at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_i_s) begin
      starve_cnt_d = 4'd0;
    end else if (grant_d_s && port.if_req) begin
      if (starve_cnt_q < LIMIT) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end else begin
        starve_cnt_d = starve_cnt_q;
      end
    end else if ((state_q == IDLE) && !port.if_req) begin
      starve_cnt_d = 4'd0;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // A redirect during an in-flight fetch marks its result as stale; the bus cycle still runs to completion.
  always_comb begin
    drop_d = drop_q;
    if (state_q == DONE) begin
      drop_d = 1'b0;
    end else if (((state_q == ADDR) || (state_q == WAIT)) && (owner_q == OWN_I) && port.if_flush) begin
      drop_d = 1'b1;
    end else begin
      drop_d = drop_q;
    end
  end

  // Read data lands in the owner's holding register; it keeps its value until the owner's next completion.
  always_comb begin
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if ((state_q == WAIT) && port.bus_rvalid) begin
      if (owner_q == OWN_D) begin
        mem_rdata_d = port.bus_rdata;
      end else begin
        if_rdata_d  = port.bus_rdata;
      end
    end else begin
      if_rdata_d  = if_rdata_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      starve_cnt_q <= 4'd0;
      drop_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= {ADDR_WIDTH{1'b0}};
      wdata_q      <= {DATA_WIDTH{1'b0}};
      be_q         <= {BE_WIDTH{1'b0}};
      if_rdata_q   <= {DATA_WIDTH{1'b0}};
      mem_rdata_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      drop_q       <= drop_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
    end
  end

  // A redirect arriving in the completion cycle itself also hides the fetch result.
  assign if_done_s  = (state_q == DONE) & (owner_q == OWN_I) & ~drop_q & ~port.if_flush;
  assign mem_done_s = (state_q == DONE) & (owner_q == OWN_D);

  assign port.if_done         = if_done_s;
  assign port.mem_done        = mem_done_s;
  assign port.if_rdata        = if_rdata_q;
  assign port.mem_rdata       = mem_rdata_q;
  assign port.Icache_StallReq = port.if_req & ~if_done_s;
  assign port.Dcache_StallReq = port.mem_req & ~mem_done_s;

  assign port.bus_req   = (state_q == ADDR);
  assign port.bus_we    = we_q;
  assign port.bus_addr  = addr_q;
  assign port.bus_wdata = wdata_q;
  assign port.bus_be    = be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model built from timestamps and queues.
module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk  (clk),
    .rst  (rst),
    .port (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- transaction-level reference model ----------------
  int          cyc;
  bit          m_busy;
  int          m_t_start, m_t_gnt, m_t_rv;
  bit          m_own_d, m_drop, m_we;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_mem_rdata;
  logic [3:0]  m_be;
  int          m_starve;
  byte         grant_log[$];
  bit          exp_if_done_q, exp_mem_done_q, exp_bus_req_q;

  function automatic byte log_at(int i);
    if (i < grant_log.size()) return grant_log[i];
    return 8'h3F;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_t_start = -1; m_t_gnt = -1; m_t_rv = -1;
    m_own_d = 1'b0; m_drop = 1'b0; m_we = 1'b0;
    m_addr = 32'd0; m_wdata = 32'd0; m_be = 4'd0;
    m_if_rdata = 32'd0; m_mem_rdata = 32'd0; m_starve = 0;
    exp_if_done_q = 1'b0; exp_mem_done_q = 1'b0; exp_bus_req_q = 1'b0;
  endtask

  task automatic start_txn(input bit own_d);
    m_busy = 1'b1; m_own_d = own_d; m_drop = 1'b0;
    m_t_start = cyc; m_t_gnt = -1; m_t_rv = -1;
    grant_log.push_back(own_d ? 8'h44 : 8'h49);
  endtask

  // Compare process: on every falling edge check the DUT against the model, then advance the model.
  initial begin
    bit e_bus_req, e_done, e_if_done, e_mem_done, ie, de;
    cyc = 0;
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) begin
        model_reset();
        chk("rst_bus_req",   64'(bif.bus_req),   64'd0);
        chk("rst_if_done",   64'(bif.if_done),   64'd0);
        chk("rst_mem_done",  64'(bif.mem_done),  64'd0);
        chk("rst_if_rdata",  64'(bif.if_rdata),  64'd0);
        chk("rst_mem_rdata", 64'(bif.mem_rdata), 64'd0);
        chk("rst_bus_addr",  64'(bif.bus_addr),  64'd0);
        chk("rst_istall",    64'(bif.Icache_StallReq), 64'(bif.if_req));
        chk("rst_dstall",    64'(bif.Dcache_StallReq), 64'(bif.mem_req));
      end else begin
        e_bus_req  = m_busy && (m_t_gnt < 0);
        e_done     = m_busy && (m_t_rv >= 0);
        e_if_done  = e_done && !m_own_d && !m_drop && !bif.if_flush;
        e_mem_done = e_done && m_own_d;
        chk("bus_req",   64'(bif.bus_req),   64'(e_bus_req));
        chk("if_done",   64'(bif.if_done),   64'(e_if_done));
        chk("mem_done",  64'(bif.mem_done),  64'(e_mem_done));
        chk("if_rdata",  64'(bif.if_rdata),  64'(m_if_rdata));
        chk("mem_rdata", 64'(bif.mem_rdata), 64'(m_mem_rdata));
        chk("istall", 64'(bif.Icache_StallReq), 64'(bif.if_req && !e_if_done));
        chk("dstall", 64'(bif.Dcache_StallReq), 64'(bif.mem_req && !e_mem_done));
        if (e_bus_req) begin
          chk("bus_we",   64'(bif.bus_we),   64'(m_we));
          chk("bus_addr", 64'(bif.bus_addr), 64'(m_addr));
          if (m_own_d) begin
            chk("bus_wdata", 64'(bif.bus_wdata), 64'(m_wdata));
            chk("bus_be",    64'(bif.bus_be),    64'(m_be));
          end
        end
        exp_if_done_q  = e_if_done;
        exp_mem_done_q = e_mem_done;
        exp_bus_req_q  = e_bus_req;

        if (!m_busy) begin
          ie = bif.if_req && !bif.if_flush;
          de = bif.mem_req;
          if (de && !(ie && m_starve == LIMIT)) begin
            start_txn(1'b1);
            m_we = bif.mem_we; m_addr = bif.mem_addr; m_wdata = bif.mem_wdata; m_be = bif.mem_be;
            m_starve = bif.if_req ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
          end else if (ie) begin
            start_txn(1'b0);
            m_we = 1'b0; m_addr = bif.if_addr;
            m_starve = 0;
          end else if (!bif.if_req) begin
            m_starve = 0;
          end
        end else if (m_t_gnt < 0) begin
          if (bif.if_flush && !m_own_d) m_drop = 1'b1;
          if (bif.bus_gnt) m_t_gnt = cyc;
        end else if (m_t_rv < 0) begin
          if (bif.if_flush && !m_own_d) m_drop = 1'b1;
          if (bif.bus_rvalid) begin
            m_t_rv = cyc;
            if (m_own_d) m_mem_rdata = bif.bus_rdata;
            else         m_if_rdata  = bif.bus_rdata;
          end
        end else begin
          m_busy = 1'b0;
          m_drop = 1'b0;
        end
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bus(input bit g, input bit rv, input logic [31:0] rd);
    bif.bus_gnt = g; bif.bus_rvalid = rv; bif.bus_rdata = rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  base;
    byte seq[$];
    bit  id, md;
    logic [47:0] packed_seq;

    rst = 1'b1;
    bif.if_req = 1'b0; bif.if_addr = 32'd0; bif.if_flush = 1'b0;
    bif.mem_req = 1'b0; bif.mem_we = 1'b0; bif.mem_addr = 32'd0; bif.mem_wdata = 32'd0; bif.mem_be = 4'd0;
    drive_bus(1'b0, 1'b0, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single fetch: minimum latency, done in cycle 3.
    tick; bif.if_req = 1'b1; bif.if_addr = 32'h100;
    #1 chk("fetch_stall_c0", 64'(bif.Icache_StallReq), 64'd1);
    tick; drive_bus(1'b1, 1'b0, 32'd0);
    #1 chk("fetch_bus_req", 64'(bif.bus_req), 64'd1);
    chk("fetch_bus_addr", 64'(bif.bus_addr), 64'h100);
    tick; drive_bus(1'b0, 1'b1, 32'h00000013);
    #1 chk("fetch_stall_c2", 64'(bif.Icache_StallReq), 64'd1);
    tick; drive_bus(1'b0, 1'b0, 32'd0);
    #1 chk("fetch_done_c3", 64'(bif.if_done), 64'd1);
    chk("fetch_rdata", 64'(bif.if_rdata), 64'h13);
    chk("fetch_stall_c3", 64'(bif.Icache_StallReq), 64'd0);
    tick; bif.if_req = 1'b0;
    #1 chk("fetch_rdata_hold", 64'(bif.if_rdata), 64'h13);

    // Store priority over a simultaneous fetch.
    base = grant_log.size();
    tick; bif.if_req = 1'b1; bif.if_addr = 32'h200;
    bif.mem_req = 1'b1; bif.mem_we = 1'b1; bif.mem_addr = 32'h2000; bif.mem_wdata = 32'hDEADBEEF; bif.mem_be = 4'hF;
    tick; drive_bus(1'b1, 1'b0, 32'd0);
    #1 chk("prio_we", 64'(bif.bus_we), 64'd1);
    chk("prio_addr",  64'(bif.bus_addr),  64'h2000);
    chk("prio_wdata", 64'(bif.bus_wdata), 64'hDEADBEEF);
    chk("prio_be",    64'(bif.bus_be),    64'hF);
    tick; drive_bus(1'b0, 1'b1, 32'h55);
    tick; drive_bus(1'b0, 1'b0, 32'd0);
    #1 chk("prio_mem_done", 64'(bif.mem_done), 64'd1);
    tick; bif.mem_req = 1'b0; bif.mem_we = 1'b0;
    tick; drive_bus(1'b1, 1'b0, 32'd0);
    #1 chk("prio_fetch_addr", 64'(bif.bus_addr), 64'h200);
    tick; drive_bus(1'b0, 1'b1, 32'h77);
    tick; drive_bus(1'b0, 1'b0, 32'd0);
    #1 chk("prio_if_done", 64'(bif.if_done), 64'd1);
    chk("prio_if_rdata", 64'(bif.if_rdata), 64'h77);
    tick; bif.if_req = 1'b0;
    chk("prio_model_order", 64'({log_at(base), log_at(base + 1)}), 64'h4449);

    // Starvation limit: D back-to-back with fetch pending.
    base = grant_log.size();
    tick; bif.if_req = 1'b1; bif.if_addr = 32'h300;
    bif.mem_req = 1'b1; bif.mem_we = 1'b0; bif.mem_addr = 32'h4000; bif.mem_be = 4'hF;
    drive_bus(1'b1, 1'b1, 32'h1234);
    for (int n = 0; n < 60 && seq.size() < 6; n++) begin
      #1;
      id = bif.if_done; md = bif.mem_done;
      if (id) seq.push_back(8'h49);
      if (md) seq.push_back(8'h44);
      tick;
      if (md) bif.mem_addr = bif.mem_addr + 32'd4;
      if (id) bif.if_req = 1'b0;
    end
    bif.mem_req = 1'b0; bif.if_req = 1'b0;
    drive_bus(1'b0, 1'b0, 32'd0);
    packed_seq = 48'd0;
    for (int i = 0; i < 6; i++) packed_seq = {packed_seq[39:0], (i < seq.size()) ? seq[i] : 8'h3F};
    chk("starve_dut_order", 64'(packed_seq), 64'h444444444944);
    packed_seq = 48'd0;
    for (int i = 0; i < 6; i++) packed_seq = {packed_seq[39:0], log_at(base + i)};
    chk("starve_model_order", 64'(packed_seq), 64'h444444444944);
    repeat (2) tick;

    // Flush while the fetch is in WAIT.
    tick; bif.if_req = 1'b1; bif.if_addr = 32'h400;
    tick; drive_bus(1'b1, 1'b0, 32'd0);
    tick; drive_bus(1'b0, 1'b0, 32'd0); bif.if_flush = 1'b1; bif.if_addr = 32'h500;
    tick; bif.if_flush = 1'b0; drive_bus(1'b0, 1'b1, 32'h99);
    #1 chk("flush_no_done_wait", 64'(bif.if_done), 64'd0);
    tick; drive_bus(1'b0, 1'b0, 32'd0);
    #1 chk("flush_no_done", 64'(bif.if_done), 64'd0);
    chk("flush_bus_idle", 64'(bif.bus_req), 64'd0);
    tick;
    tick; drive_bus(1'b1, 1'b0, 32'd0);
    #1 chk("flush_new_addr", 64'(bif.bus_addr), 64'h500);
    tick; drive_bus(1'b0, 1'b1, 32'hAB);
    tick; drive_bus(1'b0, 1'b0, 32'd0);
    #1 chk("flush_refetch_done", 64'(bif.if_done), 64'd1);
    chk("flush_refetch_data", 64'(bif.if_rdata), 64'hAB);
    tick; bif.if_req = 1'b0;

    // Delayed grant: latched address survives requester changes.
    tick; bif.mem_req = 1'b1; bif.mem_we = 1'b0; bif.mem_addr = 32'h3000; bif.mem_wdata = 32'd0; bif.mem_be = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick; bif.mem_addr = $urandom;
      #1 chk("dly_bus_req", 64'(bif.bus_req), 64'd1);
      chk("dly_bus_addr", 64'(bif.bus_addr), 64'h3000);
    end
    tick; drive_bus(1'b1, 1'b0, 32'd0);
    #1 chk("dly_addr_at_gnt", 64'(bif.bus_addr), 64'h3000);
    tick; drive_bus(1'b0, 1'b1, 32'hCAFE);
    tick; drive_bus(1'b0, 1'b0, 32'd0);
    #1 chk("dly_mem_done", 64'(bif.mem_done), 64'd1);
    chk("dly_mem_rdata", 64'(bif.mem_rdata), 64'hCAFE);
    tick; bif.mem_req = 1'b0;

    // Asynchronous reset in the middle of WAIT.
    tick; bif.mem_req = 1'b1; bif.mem_addr = 32'h10;
    tick; drive_bus(1'b1, 1'b0, 32'd0);
    tick; drive_bus(1'b0, 1'b0, 32'd0);
    #2 rst = 1'b1;
    #1 chk("arst_bus_req", 64'(bif.bus_req), 64'd0);
    chk("arst_mem_rdata", 64'(bif.mem_rdata), 64'd0);
    chk("arst_mem_done",  64'(bif.mem_done),  64'd0);
    tick; rst = 1'b0; bif.mem_req = 1'b0; drive_bus(1'b0, 1'b1, 32'h5A5A);
    for (int k = 0; k < 4; k++) begin
      tick;
      #1 chk("arst_no_done", 64'(bif.mem_done), 64'd0);
    end
    drive_bus(1'b0, 1'b0, 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      tick;
      drive_bus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 9) == 0) begin
        bif.if_flush = 1'b1; bif.if_addr = $urandom;
      end else begin
        bif.if_flush = 1'b0;
      end
      if (!bif.if_req) begin
        if ($urandom_range(0, 2) == 0) begin bif.if_req = 1'b1; bif.if_addr = $urandom; end
      end else if (exp_if_done_q) begin
        if ($urandom_range(0, 1) == 0) bif.if_req = 1'b0;
        else bif.if_addr = $urandom;
      end
      if (!bif.mem_req || exp_mem_done_q) begin
        if ($urandom_range(0, 2) == 0) begin
          bif.mem_req = 1'b1; bif.mem_we = 1'($urandom_range(0, 1));
          bif.mem_addr = $urandom; bif.mem_wdata = $urandom; bif.mem_be = 4'($urandom);
        end else begin
          bif.mem_req = 1'b0;
        end
      end else if (exp_bus_req_q && m_own_d && $urandom_range(0, 3) == 0) begin
        bif.mem_addr = $urandom; bif.mem_wdata = $urandom;
        bif.mem_we = 1'($urandom_range(0, 1)); bif.mem_be = 4'($urandom);
      end
    end

    repeat (2) tick;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
